// File: rtl/cop0_pkg.sv
// CP0 shared definitions: register numbers, Status/Cause field positions,
// write masks, reset constants, the ExcCode enumeration and a masked-write
// helper used for the partially writable registers.
package cop0_pkg;

  // CP0 register numbers (rd field of MTC0/MFC0), all at sel 0
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // Status bit positions
  localparam int unsigned ST_IE     = 0;
  localparam int unsigned ST_EXL    = 1;
  localparam int unsigned ST_ERL    = 2;
  localparam int unsigned ST_IM_LO  = 8;
  localparam int unsigned ST_IM_HI  = 15;
  localparam int unsigned ST_BEV    = 22;

  // Cause bit positions
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_IP_HW  = 10;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

  // Software-writable bits
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Reset values
  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0] CAUSE_RESET  = 32'h0000_0000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cop0_timer.sv
// CP0 Count/Compare timer.
// Ports: clk, reset_n (async active-low); count_we/compare_we load wdata into
// Count/Compare; count, compare and ti are the registered state; ti_next is
// the value ti takes at the coming edge (feeds Cause.IP[7]).
module cop0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti,
  output logic        ti_next
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_d, compare_d;
  logic          count_upd;

  always_comb begin
    presc_d   = presc_q + PW'(1);
    count_d   = count;
    count_upd = 1'b0;
    if (count_we) begin
      // a software load overrides the increment and restarts the prescaler
      presc_d   = '0;
      count_d   = wdata;
      count_upd = 1'b1;
    end else if (presc_q == PRESC_LAST) begin
      presc_d   = '0;
      count_d   = count + 32'd1;
      count_upd = 1'b1;
    end
    compare_d = compare_we ? wdata : compare;
    // match is against the old Compare; a Compare write always wins and clears
    ti_next   = compare_we ? 1'b0 : (ti | (count_upd & (count_d == compare)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count   <= count_d;
      compare <= compare_d;
      ti      <= ti_next;
    end
  end

endmodule

// File: rtl/cop0_controller.sv
// CP0 controller: owns BadVAddr, Count, Compare, Status, Cause, EPC, PRId and
// serialises MTC0, exception commit, ERET, hardware interrupts and the timer.
// Ports: clk, reset_n (async active-low); mtc0_* write port; mfc0_addr/sel ->
// mfc0_data combinational read; exc_* exception commit; eret; hw_int[5:0]
// level interrupts; int_pending registered request; epc_out, status_out,
// timer_int (Cause.TI).
module cop0_controller
  import cop0_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_data,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badva_valid,
  input  logic [31:0] exc_badva,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic        timer_int
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d, cause_rd;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        int_pending_d;

  logic        eret_take, mtc0_take;
  logic        count_we, compare_we;
  logic [31:0] count, compare;
  logic        ti, ti_next;

  // exception > eret > mtc0; losers belong to squashed instructions
  assign eret_take  = eret & ~exc_valid;
  assign mtc0_take  = mtc0_en & ~exc_valid & ~eret & (mtc0_sel == 3'd0);
  assign count_we   = mtc0_take & (mtc0_addr == REG_COUNT);
  assign compare_we = mtc0_take & (mtc0_addr == REG_COMPARE);

  cop0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (mtc0_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti),
    .ti_next    (ti_next)
  );

  // TI lives in the timer; the stored cause_q keeps bit 30 at zero
  assign cause_rd = cause_q | ({31'd0, ti} << CAUSE_TI);

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (exc_valid) begin
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
      if (!status_q[ST_EXL]) begin
        epc_d             = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        cause_d[CAUSE_BD] = exc_bd;
      end
      status_d[ST_EXL] = 1'b1;
      if (exc_badva_valid) begin
        badvaddr_d = exc_badva;
      end
    end else if (eret_take) begin
      if (status_q[ST_ERL]) begin
        status_d[ST_ERL] = 1'b0;
      end else begin
        status_d[ST_EXL] = 1'b0;
      end
    end else if (mtc0_take) begin
      case (mtc0_addr)
        REG_STATUS:   status_d   = masked_write(status_q, mtc0_data, STATUS_WMASK);
        REG_CAUSE:    cause_d    = masked_write(cause_q, mtc0_data, CAUSE_WMASK);
        REG_EPC:      epc_d      = mtc0_data;
        REG_BADVADDR: badvaddr_d = mtc0_data;
        default:      ;
      endcase
    end
    // hardware IP bits are resampled every cycle; IP7 also carries the timer
    cause_d[CAUSE_IP_HI:CAUSE_IP_HW] = {hw_int[5] | ti_next, hw_int[4:0]};
    cause_d[CAUSE_TI]                = 1'b0;
  end

  assign int_pending_d = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL] &
                         (|(cause_q[CAUSE_IP_HI:CAUSE_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q    <= STATUS_RESET;
      cause_q     <= CAUSE_RESET;
      epc_q       <= '0;
      badvaddr_q  <= '0;
      int_pending <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      int_pending <= int_pending_d;
    end
  end

  always_comb begin
    mfc0_data = '0;
    if (mfc0_sel == 3'd0) begin
      case (mfc0_addr)
        REG_BADVADDR: mfc0_data = badvaddr_q;
        REG_COUNT:    mfc0_data = count;
        REG_COMPARE:  mfc0_data = compare;
        REG_STATUS:   mfc0_data = status_q;
        REG_CAUSE:    mfc0_data = cause_rd;
        REG_EPC:      mfc0_data = epc_q;
        REG_PRID:     mfc0_data = PRID;
        default:      mfc0_data = '0;
      endcase
    end
  end

  assign epc_out    = epc_q;
  assign status_out = status_q;
  assign timer_int  = ti;

endmodule

// File: tb/tb_cop0_controller.sv
// Scoreboard bench for cop0_controller: directed scenarios followed by random
// traffic, with expectations from a behavioural CP0 model.
module tb_cop0_controller;
  import cop0_pkg::*;

  localparam logic [31:0] PRID_V = 32'h0001_8000;
  localparam int unsigned DIV    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [2:0]  mfc0_sel;
  logic [31:0] mfc0_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badva_valid;
  logic [31:0] exc_badva;
  logic        eret;
  logic [5:0]  hw_int;
  logic        int_pending;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic        timer_int;

  cop0_controller #(.PRID(PRID_V), .COUNT_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_sel(mfc0_sel), .mfc0_data(mfc0_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva_valid(exc_badva_valid), .exc_badva(exc_badva), .eret(eret),
    .hw_int(hw_int), .int_pending(int_pending), .epc_out(epc_out),
    .status_out(status_out), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mtc0_en;
    logic [4:0]  mtc0_addr;
    logic [2:0]  mtc0_sel;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [2:0]  mfc0_sel;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_badva_valid;
    logic [31:0] exc_badva;
    logic        eret;
    logic [5:0]  hw_int;
  } stim_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] epc;
    logic [31:0] status;
    logic        pend;
    logic        ti;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [5:0]  hw_level = '0;

  // ---------------- reference model ----------------
  logic [31:0] m_status, m_epc, m_badva, m_count, m_compare;
  logic        m_bd, m_ti, m_pend;
  logic [4:0]  m_exc;
  logic [7:0]  m_ip;     // Cause.IP[15:8]
  int unsigned m_phase;  // clocks since Count was last loaded or reset

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd8:    return m_badva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0004;
    m_epc = 0; m_badva = 0; m_count = 0; m_compare = 0;
    m_bd = 0; m_ti = 0; m_pend = 0; m_exc = 0; m_ip = 0; m_phase = 0;
  endtask

  task automatic model_step(input stim_t s);
    bit take_exc, take_eret, take_mt, tick, moved, pend_new;
    logic [31:0] nxt;
    take_exc  = s.exc_valid;
    take_eret = s.eret && !s.exc_valid;
    take_mt   = s.mtc0_en && !s.exc_valid && !s.eret && (s.mtc0_sel == 0);
    pend_new  = m_status[0] && !m_status[1] && !m_status[2] && ((m_ip & m_status[15:8]) != 0);
    tick      = (m_phase % DIV) == (DIV - 1);
    if (take_mt && s.mtc0_addr == 5'd9) begin
      nxt = s.mtc0_data; m_phase = 0; moved = 1;
    end else begin
      nxt = tick ? m_count + 32'd1 : m_count; moved = tick; m_phase++;
    end
    if (take_mt && s.mtc0_addr == 5'd11) begin
      m_compare = s.mtc0_data; m_ti = 0;
    end else if (moved && nxt == m_compare) begin
      m_ti = 1;
    end
    m_count = nxt;
    if (take_mt && s.mtc0_addr == 5'd13) m_ip[1:0] = s.mtc0_data[9:8];
    m_ip[7:2] = {s.hw_int[5] | m_ti, s.hw_int[4:0]};
    if (take_exc) begin
      m_exc = s.exc_code;
      if (!m_status[1]) begin
        m_epc = s.exc_bd ? s.exc_pc - 32'd4 : s.exc_pc;
        m_bd  = s.exc_bd;
      end
      m_status[1] = 1;
      if (s.exc_badva_valid) m_badva = s.exc_badva;
    end else if (take_eret) begin
      if (m_status[2]) m_status[2] = 0; else m_status[1] = 0;
    end else if (take_mt) begin
      if (s.mtc0_addr == 5'd12)
        m_status = (m_status & ~32'h0040_FF07) | (s.mtc0_data & 32'h0040_FF07);
      else if (s.mtc0_addr == 5'd14) m_epc = s.mtc0_data;
      else if (s.mtc0_addr == 5'd8)  m_badva = s.mtc0_data;
    end
    m_pend = pend_new;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic stim_t idle();
    stim_t s;
    s.mtc0_en = 0; s.mtc0_addr = 0; s.mtc0_sel = 0; s.mtc0_data = 0;
    s.mfc0_addr = 5'd12; s.mfc0_sel = 0;
    s.exc_valid = 0; s.exc_code = 0; s.exc_pc = 0; s.exc_bd = 0;
    s.exc_badva_valid = 0; s.exc_badva = 0; s.eret = 0; s.hw_int = hw_level;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    mtc0_en = s.mtc0_en; mtc0_addr = s.mtc0_addr; mtc0_sel = s.mtc0_sel;
    mtc0_data = s.mtc0_data; mfc0_addr = s.mfc0_addr; mfc0_sel = s.mfc0_sel;
    exc_valid = s.exc_valid; exc_code = s.exc_code; exc_pc = s.exc_pc;
    exc_bd = s.exc_bd; exc_badva_valid = s.exc_badva_valid; exc_badva = s.exc_badva;
    eret = s.eret; hw_int = s.hw_int;
  endtask

  // drive one cycle: push the expectation for the state visible before the edge
  task automatic cycle(input stim_t s, input bit use_const, input logic [31:0] cval,
                       input string tag);
    exp_t e;
    apply(s);
    e.rd = use_const ? cval : m_read(s.mfc0_addr, s.mfc0_sel);
    e.epc = m_epc; e.status = m_status; e.pend = m_pend; e.ti = m_ti; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    model_step(s);
  endtask

  task automatic rd(input logic [4:0] a, input string tag);
    stim_t s = idle();
    s.mfc0_addr = a;
    cycle(s, 0, 0, tag);
  endtask

  task automatic rdc(input logic [4:0] a, input logic [31:0] v, input string tag);
    stim_t s = idle();
    s.mfc0_addr = a;
    cycle(s, 1, v, tag);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string tag);
    stim_t s = idle();
    s.mtc0_en = 1; s.mtc0_addr = a; s.mtc0_data = d; s.mfc0_addr = a;
    cycle(s, 0, 0, tag);
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input bit bd,
                     input string tag);
    stim_t s = idle();
    s.exc_valid = 1; s.exc_code = code; s.exc_pc = pc; s.exc_bd = bd;
    s.exc_badva_valid = 1; s.exc_badva = pc ^ 32'h0000_0FF0; s.mfc0_addr = 5'd14;
    cycle(s, 0, 0, tag);
  endtask

  task automatic async_reset();
    exp_t e;
    stim_t s = idle();
    s.mfc0_addr = 5'd9;
    apply(s);
    #2 reset_n = 1'b0;
    model_reset();
    e.rd = 32'd0; e.epc = 0; e.status = 32'h0040_0004; e.pend = 0; e.ti = 0;
    e.tag = "async_reset";
    sb.push_back(e);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 8))
      0: return 5'd8;  1: return 5'd9;  2: return 5'd11; 3: return 5'd12;
      4: return 5'd13; 5: return 5'd14; 6: return 5'd15; 7: return 5'($urandom_range(0, 31));
      default: return 5'd12;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "mfc0_data",   mfc0_data,          e.rd);
        chk(e.tag, "epc_out",     epc_out,            e.epc);
        chk(e.tag, "status_out",  status_out,         e.status);
        chk(e.tag, "int_pending", {31'd0, int_pending}, {31'd0, e.pend});
        chk(e.tag, "timer_int",   {31'd0, timer_int},   {31'd0, e.ti});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    stim_t s;
    reset_n = 1'b0;
    model_reset();
    apply(idle());
    @(posedge clk); #1;
    reset_n = 1'b1;

    rdc(5'd12, 32'h0040_0004, "reset_status");
    rdc(5'd15, 32'h0001_8000, "reset_prid");
    rdc(5'd13, 32'h0000_0000, "reset_cause");

    wr(5'd12, 32'hFFFF_FFFF, "wr_status_all");
    rdc(5'd12, 32'h0040_FF07, "status_mask");
    wr(5'd13, 32'hFFFF_FFFF, "wr_cause_all");
    rdc(5'd13, 32'h0000_0300, "cause_mask");
    wr(5'd13, 32'h0, "clr_cause");
    wr(5'd12, 32'h0040_0004, "set_status");

    exc(EXC_SYS, 32'h8000_0104, 1'b1, "exc_bd");
    rdc(5'd14, 32'h8000_0100, "epc_bd");
    rdc(5'd13, 32'h8000_0020, "cause_bd");
    rdc(5'd12, 32'h0040_0006, "status_exl");
    exc(EXC_ADEL, 32'h0000_0200, 1'b0, "exc_nested");
    rdc(5'd14, 32'h8000_0100, "epc_held");
    rdc(5'd13, 32'h8000_0010, "cause_nested");

    s = idle();
    s.exc_valid = 1; s.exc_code = EXC_OV; s.exc_pc = 32'h300; s.eret = 1;
    s.mtc0_en = 1; s.mtc0_addr = 5'd14; s.mtc0_data = 32'h1234;
    cycle(s, 0, 0, "prio_all");
    rdc(5'd14, 32'h8000_0100, "prio_epc");
    rdc(5'd13, 32'h8000_0030, "prio_cause");
    s = idle(); s.eret = 1; cycle(s, 0, 0, "eret1");
    rdc(5'd12, 32'h0040_0002, "eret_erl");
    s = idle(); s.eret = 1; cycle(s, 0, 0, "eret2");
    rdc(5'd12, 32'h0040_0000, "eret_exl");

    wr(5'd11, 32'd5, "wr_compare5");
    wr(5'd9, 32'd0, "wr_count0");
    for (int i = 0; i < 9; i++) rd(5'd9, "timer_run");
    rdc(5'd13, 32'h8000_0030, "ti_before");
    rdc(5'd13, 32'hC000_8030, "ti_set");
    wr(5'd11, 32'd100, "wr_compare_clr");
    rdc(5'd13, 32'h8000_0030, "ti_cleared");
    wr(5'd9, 32'hFFFF_FFFF, "wr_count_max");
    rdc(5'd9, 32'hFFFF_FFFF, "count_max0");
    rdc(5'd9, 32'hFFFF_FFFF, "count_max1");
    rdc(5'd9, 32'h0000_0000, "count_wrap");

    wr(5'd12, 32'h0000_8001, "wr_status_ie");
    hw_level = 6'b100000;
    rdc(5'd13, 32'h8000_0030, "hw_sample");
    rdc(5'd13, 32'h8000_8030, "hw_ip7");
    for (int i = 0; i < 3; i++) rd(5'd13, "int_rise");
    wr(5'd12, 32'h0000_8000, "wr_status_noie");
    for (int i = 0; i < 3; i++) rd(5'd12, "int_fall");
    hw_level = '0;

    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2200) async_reset();
      if ($urandom_range(0, 15) == 0) hw_level = 6'($urandom);
      s = idle();
      s.exc_valid = ($urandom_range(0, 99) < 6);
      s.eret      = ($urandom_range(0, 99) < 6);
      s.mtc0_en   = ($urandom_range(0, 99) < 35);
      s.mtc0_addr = pick_addr();
      s.mtc0_sel  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      s.mtc0_data = $urandom;
      if (s.mtc0_addr == 5'd11 && $urandom_range(0, 1) == 1)
        s.mtc0_data = m_count + 32'($urandom_range(0, 4));
      if (s.mtc0_addr == 5'd9 && $urandom_range(0, 3) == 0)
        s.mtc0_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (s.mtc0_addr == 5'd12 && $urandom_range(0, 3) != 0)
        s.mtc0_data = (s.mtc0_data & 32'hFFFF_FFF8) | 32'h1;
      s.mfc0_addr       = pick_addr();
      s.mfc0_sel        = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      s.exc_code        = 5'($urandom_range(0, 31));
      s.exc_pc          = $urandom;
      s.exc_bd          = 1'($urandom_range(0, 1));
      s.exc_badva_valid = 1'($urandom_range(0, 1));
      s.exc_badva       = $urandom;
      cycle(s, 0, 0, "random");
    end

    apply(idle());
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cop0_controller.md
Name: cop0_controller

Overview:
- Owns the CP0 architectural state: BadVAddr, Count, Compare, Status, Cause, EPC, PRId.
- Serialises every update source against that state: MTC0 from the write-back stage, exception commit, ERET, hardware interrupt lines and the Count/Compare timer.
- Produces the MFC0 read data, the interrupt-pending request that the exception logic consumes, and the EPC/Status values the fetch stage uses.
- Sits beside the register file, driven by the decoder's write_cop0 and REG_SRC_COP0 controls.

Parameters:
- PRID, 32'h0001_8000, constant value returned for register 15 sel 0.
- COUNT_DIV, 2, number of clock cycles per Count increment; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mtc0_en  in  1  commit an MTC0 this cycle.
- mtc0_addr  in  5  CP0 register number (rd field).
- mtc0_sel  in  3  select field.
- mtc0_data  in  32  write data (rt value).
- mfc0_addr  in  5  register number to read.
- mfc0_sel  in  3  select to read.
- mfc0_data  out  32  combinational read of the current register state.
- exc_valid  in  1  exception commits this cycle.
- exc_code  in  5  ExcCode to record.
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction sits in a delay slot.
- exc_badva_valid  in  1  load BadVAddr.
- exc_badva  in  32  faulting address.
- eret  in  1  ERET commits this cycle.
- hw_int  in  6  external interrupt lines, level-sensitive.
- int_pending  out  1  registered interrupt request.
- epc_out  out  32  current EPC.
- status_out  out  32  current Status.
- timer_int  out  1  Cause.TI.

Behaviour:
- Reset values:
  - Status = 32'h0040_0004 (BEV=1, ERL=1, everything else 0).
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0.
  - Prescaler = 0, int_pending = 0, timer_int = 0.
  - Reset may assert at any point, including mid-increment; every register returns to its reset value immediately.
- Update priority within one cycle:
  - exc_valid beats eret, and eret beats mtc0_en.
  - The losing request is dropped; it belongs to a squashed instruction.
  - Timer and hw_int sampling always proceed in parallel with these.
- Exception commit:
  - Cause.ExcCode[6:2] = exc_code.
  - If Status.EXL = 0: EPC = exc_bd ? exc_pc-4 : exc_pc, and Cause.BD[31] = exc_bd.
  - If Status.EXL = 1: EPC and BD are left unchanged.
  - Status.EXL is set to 1.
  - If exc_badva_valid: BadVAddr = exc_badva.
- ERET: if Status.ERL = 1, clear ERL; otherwise clear EXL.
- MTC0 (sel must be 0; any other sel is ignored):
  - Status: only bits 22, 15:8, 2, 1, 0 are writable; all other bits hold their value.
  - Cause: only IP[9:8] is writable.
  - EPC, BadVAddr: full 32-bit write.
  - Count: load mtc0_data and clear the prescaler.
  - Compare: load mtc0_data and clear TI.
  - Writes to any other address are ignored.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1. Count increments (mod 2^32, wraps silently) on the cycle the prescaler equals COUNT_DIV-1.
  - TI (Cause bit 30) sets on the cycle the next Count value equals Compare.
  - TI stays set until Compare is written.
  - An MTC0 Count in the same cycle overrides the increment.
  - An MTC0 Compare in the same cycle as a match leaves TI clear.
- Cause.IP:
  - IP[14:10] is registered from hw_int[4:0] every cycle.
  - IP[15] is registered from hw_int[5] | TI (next-state value).
- int_pending, registered one cycle after the IP/Status state: Status.IE & ~EXL & ~ERL & |(Cause.IP[15:8] & Status.IM[15:8]).
- MFC0 read:
  - Combinational from the registered state; it does not see a same-cycle write.
  - sel != 0 or an unimplemented register reads 0.
  - Register 15 reads PRID.
- Widths: all arithmetic is 32-bit unsigned; exc_pc-4 wraps.

Decomposition:
- Extend the existing cop0 package with:
  - register numbers (BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15);
  - Status/Cause bit positions;
  - the Status write mask 32'h0040_FF07 and the Cause write mask 32'h0000_0300;
  - the reset constants;
  - an ExcCode enum.
- One sub-module, cop0_timer, holds the prescaler, Count, Compare and TI. It takes the write strobes and outputs count, compare and ti.

Test Plan:
- Reset, then read Status and PRId via MFC0 -> Status = 0x0040_0004, PRId = 0x0001_8000, int_pending = 0.
- MTC0 Status = 0xFFFF_FFFF -> reads 0x0040_FF07. MTC0 Cause = 0xFFFF_FFFF -> reads 0x0000_0300.
- exc_valid with code 8, pc 0x8000_0104, bd=1 -> EPC = 0x8000_0100, Cause = 0x8000_0020, EXL = 1. A second exception with pc 0x200 -> EPC unchanged, ExcCode updated.
- Same cycle: exc_valid, eret and MTC0 EPC=0x1234 -> only the exception takes effect. A following eret clears ERL first, then a second eret clears EXL.
- COUNT_DIV=2, Compare = 5, Count written to 0 -> TI = 1 after 10 cycles; the write to Compare clears it. Count = 0xFFFF_FFFF wraps to 0 after the next increment.
- Status = 0x0000_8001 (EXL=0, ERL=0), hw_int[5] = 1 -> IP[15] = 1 on the next edge and int_pending = 1 one edge later. Deassert IE -> int_pending = 0 within 2 cycles.
